rst_seq: RTL

RST_SEQ -- requirements
Module: rst_seq

---
 rtl/rst_seq_pkg.sv | 13 +
 rtl/rst_seq_sync.sv | 25 ++
 rtl/rst_seq.sv | 129 ++++++++++++
 3 files changed

// File: rtl/rst_seq_pkg.sv
// Shared types for the reset sequencer.
// Holds the sequencer FSM state encoding.
package rst_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RELEASE,
    DONE,
    SW_HOLD,
    SW_ACK
  } rst_seq_state_e;

endpackage

// File: rtl/rst_seq_sync.sv
// Reset-release synchronizer: STAGES flops cleared async by rst_ni.
// Ports: clk_i, rst_ni, d_i (value shifted in), q_o (synchronized).
module rst_seq_sync #(
  parameter int unsigned STAGES     = 2,
  parameter bit          ResetValue = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] q_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_q <= {STAGES{ResetValue}};
    end else begin
      q_q <= {q_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = q_q[STAGES-1];

endmodule

// File: rtl/rst_seq.sv
// Sequenced multi-domain reset release with SW reset handshake.
// Ports: clk_i, rst_ni, test_mode_i, sw_rst_req_i/ack_o,
//        rst_no[NumStages] (stage 0 first), rst_done_o.
module rst_seq
  import rst_seq_pkg::*;
#(
  parameter int unsigned NumStages   = 3,
  parameter int unsigned SyncStages  = 2,
  parameter int unsigned DelayCycles = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 test_mode_i,
  input  logic                 sw_rst_req_i,
  output logic                 sw_rst_ack_o,
  output logic [NumStages-1:0] rst_no,
  output logic                 rst_done_o
);

  localparam int unsigned CW = $clog2(DelayCycles + 1);
  localparam int unsigned IW = $clog2(NumStages + 1);
  localparam logic [CW-1:0] CntMax = CW'(DelayCycles - 1);
  localparam logic [IW-1:0] IdxMax = IW'(NumStages - 1);
  localparam logic [NumStages-1:0] One = NumStages'(1);

  if (NumStages < 1 || NumStages > 16 ||
      SyncStages < 2 || DelayCycles < 1) begin : g_chk
    $fatal(1, "rst_seq: illegal parameters");
  end

  rst_seq_state_e       state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [NumStages-1:0] rst_q, rst_d;
  logic                 done_q, done_d;
  logic                 ack_q, ack_d;
  logic                 sync;
  logic                 step;

  rst_seq_sync #(
    .STAGES     (SyncStages),
    .ResetValue (1'b0)
  ) u_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (1'b1),
    .q_o    (sync)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      rst_q   <= '0;
      done_q  <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      rst_q   <= rst_d;
      done_q  <= done_d;
      ack_q   <= ack_d;
    end
  end

  // The sync output rises at E0, which the FSM only sees one
  // edge later, so that edge already counts as the first
  // RELEASE cycle of the delay window.
  assign step = (state_q == RELEASE) ||
                (state_q == IDLE && sync);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    rst_d   = rst_q;
    done_d  = done_q;
    ack_d   = ack_q;
    unique case (state_q)
      DONE: begin
        if (sw_rst_req_i) begin
          state_d = SW_HOLD;
          rst_d   = '0;
          done_d  = 1'b0;
          cnt_d   = '0;
        end
      end
      SW_HOLD: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntMax) begin
          cnt_d   = '0;
          state_d = SW_ACK;
          ack_d   = 1'b1;
        end
      end
      SW_ACK: begin
        if (!sw_rst_req_i) begin
          ack_d   = 1'b0;
          state_d = RELEASE;
          cnt_d   = '0;
          idx_d   = '0;
        end
      end
      default: ;
    endcase
    if (step) begin
      state_d = RELEASE;
      cnt_d   = cnt_q + 1'b1;
      if (cnt_q == CntMax) begin
        cnt_d = '0;
        idx_d = idx_q + 1'b1;
        // Stages release strictly in order.
        rst_d = (rst_q << 1) | One;
        if (idx_q == IdxMax) begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end
    end
  end

  assign rst_no       = test_mode_i ? {NumStages{rst_ni}}
                                    : rst_q;
  assign rst_done_o   = test_mode_i ? rst_ni : done_q;
  assign sw_rst_ack_o = ack_q & ~test_mode_i;

endmodule
